// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MIPS multiply/divide sequencer owning HI/LO (optional MULDIV_EARLY_EXIT_EN)
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q;
  // mul: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0]   opd_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, mt_write, early_exit;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] load_acc, early_acc, step_acc;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign accept    = (state_q == IDLE) && start_i && !flush_i && !op_i[2];
  assign mt_write  = (state_q == IDLE) && start_i && !flush_i && (op_i[2:1] == 2'b10);

  assign is_signed = !op_i[0];
  assign a_neg     = is_signed && src_a_i[WIDTH-1];
  assign b_neg     = is_signed && src_b_i[WIDTH-1];
  assign a_abs     = a_neg ? -src_a_i : src_a_i;
  assign b_abs     = b_neg ? -src_b_i : src_b_i;

  assign load_acc  = op_i[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
  // Final unsigned result for the trivially-known cases: zero product, or divide-by-zero
  assign early_acc = op_i[1] ? {a_abs, {WIDTH{1'b1}}} : {2*WIDTH{1'b0}};

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_exit = op_i[1] ? (src_b_i == '0) : ((src_a_i == '0) || (src_b_i == '0));
`else
  assign early_exit = 1'b0;
`endif

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
    step_acc  = acc_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH+1])
        step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        step_acc = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_q[0])
        step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      else
        step_acc = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result and mapping onto HI/LO
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and pipeline handshake; a flush kills stall and done in the same cycle
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = early_exit ? FIXUP : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
      stall_o = 1'b0;
      done_o  = 1'b0;
    end
  end

  // Operand capture, iteration datapath and HI/LO updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= CW'(WIDTH);
        acc_q     <= early_exit ? early_acc : load_acc;
        opd_q     <= op_i[1] ? b_abs : a_abs;
        is_div_q  <= op_i[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg && op_i[1];
      end else if ((state_q == CALC) && !flush_i) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= step_acc;
      end
      if ((state_q == FIXUP) && !flush_i) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (mt_write) begin
        if (op_i[0]) lo_q <= src_a_i;
        else         hi_q <= src_a_i;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard testbench for muldiv_seq
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic        flush_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  stall;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   stall_cnt = 0;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam logic [7:0] ZLAT = 8'd2;
`else
  localparam logic [7:0] ZLAT = 8'd34;
`endif

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .flush_i(flush_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done_o and measures stall length
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        chk("hi", hi_o, e.hi);
        chk("lo", lo_o, e.lo);
        chk("stall_cycles", stall_cnt, {24'd0, e.stall});
      end
      stall_cnt = 0;
    end else if (stall_o) begin
      stall_cnt++;
    end else begin
      stall_cnt = 0;
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'd7;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  task automatic expect_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [7:0] lat);
    exp_t x;
    x.hi = hi; x.lo = lo; x.stall = lat;
    sb.push_back(x);
    start_op(op, a, b);
    wait_done(name);
  endtask

  task automatic no_done_window(input string name);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) n++;
    end
    chk(name, n, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; op_i = 3'd7; flush_i = 1'b0;
    src_a_i = '0; src_b_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'd0, stall_o}, 32'h0);
    chk("rst_done", {31'd0, done_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    expect_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 8'd34);
    expect_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd34);
    expect_op("mult_m2_3", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 8'd34);
    expect_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 8'd34);
    expect_op("div_minint", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 8'd34);
    expect_op("div_m100_7", 3'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 8'd34);
    expect_op("divu_5_0", 3'd3, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, ZLAT);
    expect_op("mult_0", 3'd0, 32'd0, 32'h12345678, 32'h00000000, 32'h00000000, ZLAT);

    // MTHI then MTLO on consecutive cycles
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; src_a_i = 32'h12345678;
    chk("mthi_stall", {31'd0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("mthi_hi", hi_o, 32'h12345678);
    op_i = 3'd5; src_a_i = 32'h9ABCDEF0;
    chk("mtlo_stall", {31'd0, stall_o}, 32'h0);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'd7;
    chk("mtlo_lo", lo_o, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi_o, 32'h12345678);

    // Preload HI/LO, then flush a divide in the middle of CALC
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; src_a_i = 32'h11111111;
    @(posedge clk); #1;
    op_i = 3'd5;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'd7;
    start_op(3'd2, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_flush_stall", {31'd0, stall_o}, 32'h1);
    flush_i = 1'b1; #1;
    chk("flush_stall", {31'd0, stall_o}, 32'h0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_hi", hi_o, 32'h11111111);
    chk("flush_lo", lo_o, 32'h11111111);
    chk("flush_idle_stall", {31'd0, stall_o}, 32'h0);
    no_done_window("flush_no_done");

    // Asynchronous reset in the middle of CALC
    start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    chk("arst_hi", hi_o, 32'h0);
    chk("arst_lo", lo_o, 32'h0);
    chk("arst_stall", {31'd0, stall_o}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    no_done_window("arst_no_done");

    expect_op("divu_after_rst", 3'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 8'd34);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
